// File: rtl/iob_rom_rr_arbiter_if.sv
// Requester/ROM bundle for the round-robin ROM arbiter.
interface iob_rom_rr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ*ADDR_W-1:0] addr_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [N_REQ-1:0]        rvalid_o;
    logic [DATA_W-1:0]       r_data_o;
    logic                    rom_en_o;
    logic [ADDR_W-1:0]       rom_addr_o;
    logic [DATA_W-1:0]       rom_data_i;

    modport slave (
        input  req_i, addr_i, rom_data_i,
        output gnt_o, rvalid_o, r_data_o, rom_en_o, rom_addr_o
    );

    modport master (
        output req_i, addr_i, rom_data_i,
        input  gnt_o, rvalid_o, r_data_o, rom_en_o, rom_addr_o
    );
endinterface

// File: rtl/iob_rom_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous ROM
// between N_REQ read requesters; data returns one cycle after grant.
module iob_rom_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input logic                  clk_i,
    input logic                  arst_n_i,
    iob_rom_rr_arbiter_if.slave  bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_nxt;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic [N_REQ-1:0]  rvalid_q;
    logic [ADDR_W-1:0] addr_sel;
    logic              hit;

    // Reset forces the grant side idle without waiting for a clock.
    assign req = bus.req_i & {N_REQ{arst_n_i}};

    always_comb begin
        gnt      = '0;
        hit      = 1'b0;
        addr_sel = '0;
        ptr_nxt  = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!hit && req[k] && k >= int'(ptr)) begin
                hit      = 1'b1;
                gnt[k]   = 1'b1;
                addr_sel = bus.addr_i[k*ADDR_W +: ADDR_W];
                ptr_nxt  = (k == N_REQ - 1) ? '0 : PW'(k + 1);
            end
        end
        // Second pass covers the wrapped part of the scan below ptr.
        for (int k = 0; k < N_REQ; k++) begin
            if (!hit && req[k] && k < int'(ptr)) begin
                hit      = 1'b1;
                gnt[k]   = 1'b1;
                addr_sel = bus.addr_i[k*ADDR_W +: ADDR_W];
                ptr_nxt  = (k == N_REQ - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ptr      <= '0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= gnt;
            if (hit) begin
                ptr <= ptr_nxt;
            end
        end
    end

    assign bus.gnt_o      = gnt;
    assign bus.rom_en_o   = hit;
    assign bus.rom_addr_o = addr_sel;
    assign bus.rvalid_o   = rvalid_q;
    assign bus.r_data_o   = bus.rom_data_i;
endmodule
